// File: rtl/logic_processor_8bit_if.sv
// Button, switch and display signals of the 8-bit bit-serial logic processor.
// The master side drives buttons/switches; the slave side (the processor) drives display/debug.
interface logic_processor_8bit_if;
   logic       LoadA;
   logic       LoadB;
   logic       Execute;
   logic [7:0] Din;
   logic [2:0] F;
   logic [1:0] R;
   logic [3:0] LED;
   logic [7:0] Aval;
   logic [7:0] Bval;
   logic [7:0] hex_seg;
   logic [3:0] hex_grid;

   modport master (
      output LoadA, LoadB, Execute, Din, F, R,
      input  LED, Aval, Bval, hex_seg, hex_grid
   );

   modport slave (
      input  LoadA, LoadB, Execute, Din, F, R,
      output LED, Aval, Bval, hex_seg, hex_grid
   );
endinterface

// File: rtl/logic_processor_8bit.sv
// Bit-serial logic processor: registers A and B, one of eight bitwise functions applied
// one bit per clock over 8 clocks, results routed back into A/B, 4-digit hex display.
module logic_processor_8bit (
   input logic                   Clk,
   input logic                   Reset,
   logic_processor_8bit_if.slave bus
);

   typedef enum logic [3:0] {IDLE, S1, S2, S3, S4, S5, S6, S7, S8, HOLD} state_t;

   state_t      stateQ, stateD;
   logic [7:0]  aQ, aD;
   logic [7:0]  bQ, bD;
   logic [1:0]  loadASyncQ, loadBSyncQ, execSyncQ;
   logic [7:0]  dinSync1Q, dinSync2Q;
   logic [17:0] refreshQ;

   logic       loadAS, loadBS, execS;
   logic       bitA, bitB, fBit;
   logic       aIn, bIn;
   logic [3:0] nibble;
   logic [3:0] gridD;
   logic [7:0] segD;

   assign loadAS = loadASyncQ[1];
   assign loadBS = loadBSyncQ[1];
   assign execS  = execSyncQ[1];
   assign bitA   = aQ[0];
   assign bitB   = bQ[0];

   // Din shares the strobe synchronizer depth so a load always captures the matching data.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         loadASyncQ <= 2'b00;
         loadBSyncQ <= 2'b00;
         execSyncQ  <= 2'b00;
         dinSync1Q  <= 8'h00;
         dinSync2Q  <= 8'h00;
         refreshQ   <= 18'd0;
         stateQ     <= IDLE;
         aQ         <= 8'h00;
         bQ         <= 8'h00;
      end else begin
         loadASyncQ <= {loadASyncQ[0], bus.LoadA};
         loadBSyncQ <= {loadBSyncQ[0], bus.LoadB};
         execSyncQ  <= {execSyncQ[0], bus.Execute};
         dinSync1Q  <= bus.Din;
         dinSync2Q  <= dinSync1Q;
         refreshQ   <= refreshQ + 18'd1;
         stateQ     <= stateD;
         aQ         <= aD;
         bQ         <= bD;
      end
   end

   always_comb begin
      fBit = 1'b0;
      case (bus.F)
         3'b000: fBit = bitA & bitB;
         3'b001: fBit = bitA | bitB;
         3'b010: fBit = bitA ^ bitB;
         3'b011: fBit = 1'b1;
         3'b100: fBit = ~(bitA & bitB);
         3'b101: fBit = ~(bitA | bitB);
         3'b110: fBit = ~(bitA ^ bitB);
         default: fBit = 1'b0;
      endcase
   end

   always_comb begin
      aIn = bitA;
      bIn = bitB;
      case (bus.R)
         2'b00: begin aIn = bitA; bIn = bitB; end
         2'b01: begin aIn = bitA; bIn = fBit; end
         2'b10: begin aIn = fBit; bIn = bitB; end
         default: begin aIn = bitB; bIn = bitA; end
      endcase
   end

   // HOLD waits for the synchronized Execute to drop so one press yields exactly one operation.
   always_comb begin
      stateD = stateQ;
      aD     = aQ;
      bD     = bQ;
      case (stateQ)
         IDLE: begin
            if (loadAS) aD = dinSync2Q;
            if (loadBS) bD = dinSync2Q;
            if (execS)  stateD = S1;
         end
         S1, S2, S3, S4, S5, S6, S7: begin
            aD     = {aIn, aQ[7:1]};
            bD     = {bIn, bQ[7:1]};
            stateD = state_t'(stateQ + 4'd1);
         end
         S8: begin
            aD     = {aIn, aQ[7:1]};
            bD     = {bIn, bQ[7:1]};
            stateD = HOLD;
         end
         HOLD: begin
            if (!execS) stateD = IDLE;
         end
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      nibble = bQ[3:0];
      gridD  = 4'b1110;
      case (refreshQ[17:16])
         2'd0: begin nibble = bQ[3:0]; gridD = 4'b1110; end
         2'd1: begin nibble = bQ[7:4]; gridD = 4'b1101; end
         2'd2: begin nibble = aQ[3:0]; gridD = 4'b1011; end
         default: begin nibble = aQ[7:4]; gridD = 4'b0111; end
      endcase
   end

   // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
   always_comb begin
      segD = 8'hFF;
      case (nibble)
         4'h0: segD = 8'hC0;
         4'h1: segD = 8'hF9;
         4'h2: segD = 8'hA4;
         4'h3: segD = 8'hB0;
         4'h4: segD = 8'h99;
         4'h5: segD = 8'h92;
         4'h6: segD = 8'h82;
         4'h7: segD = 8'hF8;
         4'h8: segD = 8'h80;
         4'h9: segD = 8'h90;
         4'hA: segD = 8'h88;
         4'hB: segD = 8'h83;
         4'hC: segD = 8'hC6;
         4'hD: segD = 8'hA1;
         4'hE: segD = 8'h86;
         default: segD = 8'h8E;
      endcase
   end

   assign bus.LED      = {execS, loadAS, loadBS, Reset};
   assign bus.Aval     = aQ;
   assign bus.Bval     = bQ;
   assign bus.hex_seg  = segD;
   assign bus.hex_grid = gridD;

endmodule

// File: tb/tb_logic_processor_8bit.sv
// Directed self-checking bench for logic_processor_8bit: loads, functions, routing,
// one-operation-per-press, mid-operation reset, ignored loads and display muxing.
module tb_logic_processor_8bit;

   logic Clk;
   logic Reset;
   int   compared;
   int   mismatched;

   logic_processor_8bit_if lpIf ();

   logic_processor_8bit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (lpIf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance n rising edges, then settle 1 time unit so checks and drives sit away from the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic loadA, input logic loadB, input logic execute,
                                input logic [7:0] din, input logic [2:0] f, input logic [1:0] r);
      lpIf.LoadA   = loadA;
      lpIf.LoadB   = loadB;
      lpIf.Execute = execute;
      lpIf.Din     = din;
      lpIf.F       = f;
      lpIf.R       = r;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b00);
      tick(3);
      compared++;
      if (lpIf.Aval !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_aval: got %h expected %h", lpIf.Aval, 8'h00);
      end
      compared++;
      if (lpIf.Bval !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_bval: got %h expected %h", lpIf.Bval, 8'h00);
      end
      compared++;
      if (lpIf.LED !== 4'b0001) begin
         mismatched++;
         $display("[TB] FAIL reset_led: got %b expected %b", lpIf.LED, 4'b0001);
      end
      compared++;
      if (lpIf.hex_grid !== 4'b1110 || lpIf.hex_seg !== 8'hC0) begin
         mismatched++;
         $display("[TB] FAIL reset_display: got grid %b seg %h expected grid 1110 seg c0",
                  lpIf.hex_grid, lpIf.hex_seg);
      end
      Reset = 1'b0;
      tick(1);
      compared++;
      if (lpIf.LED !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL release_led: got %b expected %b", lpIf.LED, 4'b0000);
      end
   endtask

   task automatic test_load();
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h33, 3'b000, 2'b00);
      tick(2);
      compared++;
      if (lpIf.Aval !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL load_a_early: got %h expected %h", lpIf.Aval, 8'h00);
      end
      tick(1);
      compared++;
      if (lpIf.Aval !== 8'h33) begin
         mismatched++;
         $display("[TB] FAIL load_a_latency: got %h expected %h", lpIf.Aval, 8'h33);
      end
      tick(1);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h55, 3'b000, 2'b00);
      tick(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b00);
      tick(4);
      compared++;
      if (lpIf.Aval !== 8'h33 || lpIf.Bval !== 8'h55) begin
         mismatched++;
         $display("[TB] FAIL load_ab: got A=%h B=%h expected A=33 B=55", lpIf.Aval, lpIf.Bval);
      end
   endtask

   task automatic test_xor_into_a();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 2'b10);
      tick(22);
      compared++;
      if (lpIf.LED[3] !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL exec_led_held: got %b expected 1", lpIf.LED[3]);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b010, 2'b10);
      tick(6);
      compared++;
      if (lpIf.Aval !== 8'h66 || lpIf.Bval !== 8'h55) begin
         mismatched++;
         $display("[TB] FAIL xor_into_a: got A=%h B=%h expected A=66 B=55", lpIf.Aval, lpIf.Bval);
      end
   endtask

   task automatic test_xnor_into_b();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b110, 2'b01);
      tick(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b110, 2'b01);
      tick(11);
      compared++;
      if (lpIf.Aval !== 8'h66 || lpIf.Bval !== 8'hCC) begin
         mismatched++;
         $display("[TB] FAIL xnor_into_b: got A=%h B=%h expected A=66 B=cc", lpIf.Aval, lpIf.Bval);
      end
   endtask

   task automatic test_swap();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b000, 2'b11);
      tick(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b11);
      tick(22);
      compared++;
      if (lpIf.Aval !== 8'hCC || lpIf.Bval !== 8'h66) begin
         mismatched++;
         $display("[TB] FAIL swap: got A=%h B=%h expected A=cc B=66", lpIf.Aval, lpIf.Bval);
      end
   endtask

   // LoadA pulses while the shift sequence runs; A must end as CC^66 regardless.
   task automatic test_load_during_shift();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 2'b10);
      tick(5);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 3'b010, 2'b10);
      tick(3);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 2'b10);
      tick(12);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b010, 2'b10);
      tick(6);
      compared++;
      if (lpIf.Aval !== 8'hAA || lpIf.Bval !== 8'h66) begin
         mismatched++;
         $display("[TB] FAIL load_ignored: got A=%h B=%h expected A=aa B=66", lpIf.Aval, lpIf.Bval);
      end
   endtask

   task automatic test_reset_mid_operation();
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 3'b010, 2'b10);
      tick(6);
      Reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b010, 2'b10);
      tick(1);
      compared++;
      if (lpIf.Aval !== 8'h00 || lpIf.Bval !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_mid_op: got A=%h B=%h expected A=00 B=00", lpIf.Aval, lpIf.Bval);
      end
      Reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h5A, 3'b010, 2'b10);
      tick(3);
      compared++;
      if (lpIf.Aval !== 8'h5A) begin
         mismatched++;
         $display("[TB] FAIL idle_after_reset: got A=%h expected 5a", lpIf.Aval);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b00);
      tick(3);
   endtask

   // Refresh counter equals the number of edges since the reset edge.
   task automatic test_display();
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 3'b000, 2'b00);
      tick(4);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 3'b000, 2'b00);
      tick(4);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b00);
      tick(3);
      compared++;
      if (lpIf.Aval !== 8'h3C || lpIf.Bval !== 8'hA5) begin
         mismatched++;
         $display("[TB] FAIL display_load: got A=%h B=%h expected A=3c B=a5", lpIf.Aval, lpIf.Bval);
      end
      compared++;
      if (lpIf.hex_grid !== 4'b1110 || lpIf.hex_seg !== 8'h92) begin
         mismatched++;
         $display("[TB] FAIL digit0: got grid %b seg %h expected grid 1110 seg 92",
                  lpIf.hex_grid, lpIf.hex_seg);
      end
      tick(65535 - 11);
      compared++;
      if (lpIf.hex_grid !== 4'b1110) begin
         mismatched++;
         $display("[TB] FAIL digit0_last: got grid %b expected 1110", lpIf.hex_grid);
      end
      tick(1);
      compared++;
      if (lpIf.hex_grid !== 4'b1101 || lpIf.hex_seg !== 8'h88) begin
         mismatched++;
         $display("[TB] FAIL digit1: got grid %b seg %h expected grid 1101 seg 88",
                  lpIf.hex_grid, lpIf.hex_seg);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      Reset      = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 2'b00);
      test_reset();
      test_load();
      test_xor_into_a();
      test_xnor_into_b();
      test_swap();
      test_load_during_shift();
      test_reset_mid_operation();
      test_display();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
